mem_port_arbiter: RTL and testbench

Two-port arbiter that shares one downstream memory port between two cache clients (instruction-side port 0, data-side port 1), each with the cache's memory interface: level-held burst read requests returning one 32-bit line, and single-cycle byte write pulses. It buffers each port's write, serializes one memory transaction at a time, and routes the read response back to the owning port. It sits between the caches and the memory model.

---
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between two cache
// clients (port 0 = instruction side, port 1 = data side).
// - Each port owns a one-entry write buffer; a buffered write is always sent
//   to memory before that port's read so read-after-write order holds.
// - One memory transaction is outstanding at a time. The read line is routed
//   back to the owning port, and completion pulses are combinational.
// - Optional build macro MEM_ARB_RR_EN: round-robin arbitration between the
//   ports. When it is undefined, port 0 has fixed priority.
module mem_port_arbiter #(
  parameter int AW = 13,
  parameter int LW = 32,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  // port 0 (instruction side)
  input  logic          p0_rreq,
  input  logic [AW-1:0] p0_raddr,
  input  logic          p0_wreq,
  input  logic [AW-1:0] p0_waddr,
  input  logic [BW-1:0] p0_wdata,
  output logic [LW-1:0] p0_rdata,
  output logic          p0_rvalid,
  output logic          p0_wdone,
  output logic          p0_wfull,
  // port 1 (data side)
  input  logic          p1_rreq,
  input  logic [AW-1:0] p1_raddr,
  input  logic          p1_wreq,
  input  logic [AW-1:0] p1_waddr,
  input  logic [BW-1:0] p1_wdata,
  output logic [LW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic          p1_wdone,
  output logic          p1_wfull,
  // sticky dropped-write flag
  output logic          overflow,
  // downstream memory port
  output logic          mem_rreq,
  output logic [AW-1:0] mem_raddr,
  input  logic [LW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          mem_wreq,
  output logic [AW-1:0] mem_waddr,
  output logic [BW-1:0] mem_wdata,
  input  logic          mem_wdone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          owner;        // port that owns the outstanding transaction
  logic          grant;        // a new transaction starts this cycle
  logic          winner;       // port chosen when granting

  // Port inputs gathered into arrays so both ports share one code path.
  logic [1:0]    rreq_in, wreq_in;
  logic [AW-1:0] raddr_in [2];
  logic [AW-1:0] waddr_in [2];
  logic [BW-1:0] wdata_in [2];

  assign rreq_in     = {p1_rreq, p0_rreq};
  assign wreq_in     = {p1_wreq, p0_wreq};
  assign raddr_in[0] = p0_raddr;
  assign raddr_in[1] = p1_raddr;
  assign waddr_in[0] = p0_waddr;
  assign waddr_in[1] = p1_waddr;
  assign wdata_in[0] = p0_wdata;
  assign wdata_in[1] = p1_wdata;

  // One-entry write buffer per port.
  logic [1:0]    wbuf_valid;
  logic [AW-1:0] wbuf_addr [2];
  logic [BW-1:0] wbuf_data [2];
  logic [1:0]    wbuf_clr;     // owner's buffered write completes this cycle
  logic [1:0]    wbuf_accept;  // incoming write pulse is taken this cycle
  logic [1:0]    cand;         // ports with something to send to memory

  assign wbuf_clr    = (state == ST_WRITE && mem_wdone) ? {owner, ~owner} : 2'b00;
  assign wbuf_accept = wreq_in & (~wbuf_valid | wbuf_clr);
  assign cand        = wbuf_valid | rreq_in;

`ifdef MEM_ARB_RR_EN
  logic prio;  // port preferred when both ports are candidates

  assign winner = (&cand) ? prio : cand[1];

  // After every grant, prefer the port that did not win.
  always_ff @(posedge clk) begin
    if (reset)      prio <= 1'b0;
    else if (grant) prio <= ~winner;
  end
`else
  // Fixed priority: port 0 wins whenever it is a candidate.
  assign winner = ~cand[0];
`endif

  // State register: FSM state and transaction owner.
  // NOTE: clocked state uses non-blocking assignments, so every flop sees
  // the values from before the edge no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) owner <= winner;
    end
  end

  // Next-state logic: start a transaction from IDLE, return on its response.
  // NOTE: defaults at the top of each combinational block give every path a
  // value, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|cand) begin
          grant     = 1'b1;
          state_nxt = wbuf_valid[winner] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ:  if (mem_rvalid) state_nxt = ST_IDLE;
      ST_WRITE: if (mem_wdone)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: route the memory response to the owning port only.
  always_comb begin
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_wdone  = 1'b0;
    p1_wdone  = 1'b0;
    if (state == ST_READ && mem_rvalid) begin
      p0_rvalid = ~owner;
      p1_rvalid = owner;
    end
    if (state == ST_WRITE && mem_wdone) begin
      p0_wdone = ~owner;
      p1_wdone = owner;
    end
  end

  assign p0_rdata = mem_rdata;
  assign p1_rdata = mem_rdata;
  assign p0_wfull = wbuf_valid[0];
  assign p1_wfull = wbuf_valid[1];

  // Registered memory request. The request is held for the whole transaction
  // and address/data are captured once, when the grant is made.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rreq  <= 1'b0;
      mem_wreq  <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_rreq <= (state_nxt == ST_READ);
      mem_wreq <= (state_nxt == ST_WRITE);
      if (grant && !wbuf_valid[winner]) mem_raddr <= raddr_in[winner];
      if (grant && wbuf_valid[winner]) begin
        mem_waddr <= wbuf_addr[winner];
        mem_wdata <= wbuf_data[winner];
      end
    end
  end

  // Write-buffer occupancy. A pulse is taken when the buffer is empty or is
  // being emptied in this same cycle.
  always_ff @(posedge clk) begin
    if (reset) wbuf_valid <= 2'b00;
    else       wbuf_valid <= wbuf_accept | (wbuf_valid & ~wbuf_clr);
  end

  // Write-buffer payload.
  // NOTE: the payload is not reset. It is only read while its valid bit is
  // set, so only the valid bits need a reset value.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (wbuf_accept[n]) begin
        wbuf_addr[n] <= waddr_in[n];
        wbuf_data[n] <= wdata_in[n];
      end
    end
  end

  // Sticky overflow: set when a write pulse finds its buffer still occupied.
  always_ff @(posedge clk) begin
    if (reset)                                   overflow <= 1'b0;
    else if (|(wreq_in & wbuf_valid & ~wbuf_clr)) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives directed scenarios and then random traffic into
// mem_port_arbiter. The bench plays both cache clients and the memory. A
// transaction-level reference model predicts every DUT output on every cycle.
// Building with MEM_ARB_RR_EN selects the round-robin expectations.
module tb_mem_port_arbiter;
  localparam int AW = 13;
  localparam int LW = 32;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic          reset;
  logic [1:0]    rreq, wreq;
  logic [AW-1:0] raddr [2];
  logic [AW-1:0] waddr [2];
  logic [BW-1:0] wdata [2];
  logic [LW-1:0] mem_rdata;
  logic          mem_rvalid, mem_wdone;

  // DUT outputs
  wire [LW-1:0]  p0_rdata, p1_rdata;
  wire [1:0]     rvalid_o, wdone_o, wfull_o;
  wire           overflow;
  wire           mem_rreq, mem_wreq;
  wire [AW-1:0]  mem_raddr, mem_waddr;
  wire [BW-1:0]  mem_wdata;

  mem_port_arbiter #(.AW(AW), .LW(LW), .BW(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_rreq    (rreq[0]),
    .p0_raddr   (raddr[0]),
    .p0_wreq    (wreq[0]),
    .p0_waddr   (waddr[0]),
    .p0_wdata   (wdata[0]),
    .p0_rdata   (p0_rdata),
    .p0_rvalid  (rvalid_o[0]),
    .p0_wdone   (wdone_o[0]),
    .p0_wfull   (wfull_o[0]),
    .p1_rreq    (rreq[1]),
    .p1_raddr   (raddr[1]),
    .p1_wreq    (wreq[1]),
    .p1_waddr   (waddr[1]),
    .p1_wdata   (wdata[1]),
    .p1_rdata   (p1_rdata),
    .p1_rvalid  (rvalid_o[1]),
    .p1_wdone   (wdone_o[1]),
    .p1_wfull   (wfull_o[1]),
    .overflow   (overflow),
    .mem_rreq   (mem_rreq),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wreq   (mem_wreq),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wdone  (mem_wdone)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit            busy;
    bit            is_wr;
    bit            port;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } txn_t;

  typedef struct {
    bit            v;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wbuf_t;

  txn_t          cur;          // memory transaction in flight, if any
  wbuf_t         mbuf [2];     // each client's pending write
  bit            m_ovf;
  bit            m_ptr;        // port preferred on a tie (round-robin only)
  logic [AW-1:0] m_raddr, m_waddr;
  logic [BW-1:0] m_wdata;
  bit            exp_rv [2];
  bit            exp_wd [2];

  task automatic model_reset();
    cur     = '{busy: 1'b0, is_wr: 1'b0, port: 1'b0, addr: '0, data: '0};
    for (int n = 0; n < 2; n++) mbuf[n] = '{v: 1'b0, addr: '0, data: '0};
    m_ovf   = 1'b0;
    m_ptr   = 1'b0;
    m_raddr = '0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    bit       done, w;
    bit [1:0] clr, cand;
    if (reset) begin
      model_reset();
      return;
    end
    done = cur.busy && (cur.is_wr ? mem_wdone : mem_rvalid);
    clr  = 2'b00;
    if (done && cur.is_wr) clr[cur.port] = 1'b1;
    for (int n = 0; n < 2; n++) cand[n] = mbuf[n].v || rreq[n];
    if (done) begin
      cur.busy = 1'b0;
    end else if (!cur.busy && cand != 2'b00) begin
`ifdef MEM_ARB_RR_EN
      if (cand == 2'b11) w = m_ptr;
      else               w = cand[0] ? 1'b0 : 1'b1;
      m_ptr = !w;
`else
      w = cand[0] ? 1'b0 : 1'b1;
`endif
      cur.busy  = 1'b1;
      cur.port  = w;
      cur.is_wr = mbuf[w].v;
      if (cur.is_wr) begin
        cur.addr = mbuf[w].addr;
        cur.data = mbuf[w].data;
        m_waddr  = cur.addr;
        m_wdata  = cur.data;
      end else begin
        cur.addr = raddr[w];
        m_raddr  = cur.addr;
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (wreq[n]) begin
        if (!mbuf[n].v || clr[n]) mbuf[n] = '{v: 1'b1, addr: waddr[n], data: wdata[n]};
        else                      m_ovf = 1'b1;
      end else if (clr[n]) begin
        mbuf[n].v = 1'b0;
      end
    end
  endtask

  // Compare every DUT output with the model for the current cycle.
  task automatic check_outputs();
    check("mem_rreq",  32'(mem_rreq),  32'(cur.busy && !cur.is_wr));
    check("mem_wreq",  32'(mem_wreq),  32'(cur.busy && cur.is_wr));
    check("mem_raddr", 32'(mem_raddr), 32'(m_raddr));
    check("mem_waddr", 32'(mem_waddr), 32'(m_waddr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("p0_rdata",  p0_rdata, mem_rdata);
    check("p1_rdata",  p1_rdata, mem_rdata);
    for (int n = 0; n < 2; n++) begin
      exp_rv[n] = cur.busy && !cur.is_wr && (cur.port == 1'(n)) && mem_rvalid;
      exp_wd[n] = cur.busy && cur.is_wr && (cur.port == 1'(n)) && mem_wdone;
      check($sformatf("p%0d_rvalid", n), 32'(rvalid_o[n]), 32'(exp_rv[n]));
      check($sformatf("p%0d_wdone", n),  32'(wdone_o[n]),  32'(exp_wd[n]));
      check($sformatf("p%0d_wfull", n),  32'(wfull_o[n]),  32'(mbuf[n].v));
    end
  endtask

  // One clock: inputs were set at the falling edge. Check, clock the model,
  // then at the next falling edge retire pulses and drop answered reads.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int n = 0; n < 2; n++) if (exp_rv[n]) rreq[n] = 1'b0;
    wreq       = 2'b00;
    mem_rvalid = 1'b0;
    mem_wdone  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  logic [AW-1:0] ctn_addr [2];
  int            exp_port;

  initial begin
    reset      = 1'b1;
    rreq       = 2'b00;
    wreq       = 2'b00;
    mem_rvalid = 1'b0;
    mem_wdone  = 1'b0;
    mem_rdata  = '0;
    for (int n = 0; n < 2; n++) begin
      raddr[n] = '0;
      waddr[n] = '0;
      wdata[n] = '0;
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cycle();                  // reset held: reset values checked
    reset = 1'b0;
    idle(2);

    // Single read on port 1; memory answers 3 cycles after the request.
    rreq[1]  = 1'b1;
    raddr[1] = 13'h0A4;
    cycle();
    check("single_mem_rreq",  32'(mem_rreq),  32'h1);
    check("single_mem_raddr", 32'(mem_raddr), 32'h0A4);
    idle(2);
    mem_rdata  = 32'hDEADBEEF;
    mem_rvalid = 1'b1;
    #1;
    check("single_p1_rdata",  p1_rdata,          32'hDEADBEEF);
    check("single_p1_rvalid", 32'(rvalid_o[1]),  32'h1);
    check("single_p0_rvalid", 32'(rvalid_o[0]),  32'h0);
    cycle();
    idle(2);

    // Write buffered one cycle before a read to the same line.
    wreq[1]  = 1'b1;
    waddr[1] = 13'h010;
    wdata[1] = 8'h5A;
    cycle();
    rreq[1]  = 1'b1;
    raddr[1] = 13'h010;
    cycle();
    check("wbr_mem_wreq",  32'(mem_wreq),  32'h1);
    check("wbr_mem_rreq",  32'(mem_rreq),  32'h0);
    check("wbr_mem_waddr", 32'(mem_waddr), 32'h010);
    check("wbr_mem_wdata", 32'(mem_wdata), 32'h5A);
    cycle();
    mem_wdone = 1'b1;
    #1;
    check("wbr_p1_wdone", 32'(wdone_o[1]), 32'h1);
    cycle();
    cycle();
    check("wbr_then_rreq",  32'(mem_rreq),  32'h1);
    check("wbr_then_raddr", 32'(mem_raddr), 32'h010);
    mem_rvalid = 1'b1;
    cycle();
    idle(2);

    // Contention: both ports keep requesting, memory answers after 2 cycles.
    reset_pulse();
    ctn_addr[0] = 13'h100;
    ctn_addr[1] = 13'h200;
    raddr[0]    = ctn_addr[0];
    raddr[1]    = ctn_addr[1];
    for (int k = 0; k < 6; k++) begin
      rreq = 2'b11;
      cycle();
`ifdef MEM_ARB_RR_EN
      exp_port = k % 2;
`else
      exp_port = 0;
`endif
      check($sformatf("contend_grant_%0d", k), 32'(mem_raddr), 32'(ctn_addr[exp_port]));
      cycle();
      mem_rvalid = 1'b1;
      cycle();
    end
    rreq = 2'b00;
    idle(2);

    // Second write pulse coincident with the first write's completion.
    wreq[0] = 1'b1; waddr[0] = 13'h001; wdata[0] = 8'h11;
    cycle();
    cycle();
    wreq[0] = 1'b1; waddr[0] = 13'h002; wdata[0] = 8'h22;
    mem_wdone = 1'b1;
    cycle();
    check("coinc_overflow", 32'(overflow),   32'h0);
    check("coinc_wfull",    32'(wfull_o[0]), 32'h1);
    cycle();
    check("coinc_waddr", 32'(mem_waddr), 32'h002);
    check("coinc_wdata", 32'(mem_wdata), 32'h22);
    mem_wdone = 1'b1;
    cycle();
    idle(1);

    // Second write pulse while memory stalls: dropped, overflow sticks.
    wreq[0] = 1'b1; waddr[0] = 13'h001; wdata[0] = 8'h11;
    cycle();
    cycle();
    wreq[0] = 1'b1; waddr[0] = 13'h002; wdata[0] = 8'h22;
    cycle();
    check("drop_overflow", 32'(overflow), 32'h1);
    idle(3);
    check("drop_waddr", 32'(mem_waddr), 32'h001);
    check("drop_wdata", 32'(mem_wdata), 32'h11);
    mem_wdone = 1'b1;
    cycle();
    idle(2);
    check("drop_wfull",     32'(wfull_o[0]), 32'h0);
    check("drop_overflow2", 32'(overflow),   32'h1);

    // Reset two cycles into a read; the late response must be ignored.
    reset_pulse();
    rreq[0]  = 1'b1;
    raddr[0] = 13'h033;
    cycle();
    cycle();
    rreq[0] = 1'b0;
    reset_pulse();
    check("rst_mem_rreq", 32'(mem_rreq), 32'h0);
    mem_rvalid = 1'b1;
    #1;
    check("rst_late_p0_rvalid", 32'(rvalid_o[0]), 32'h0);
    cycle();
    rreq[1]  = 1'b1;
    raddr[1] = 13'h044;
    cycle();
    check("rst_next_rreq",  32'(mem_rreq),  32'h1);
    check("rst_next_raddr", 32'(mem_raddr), 32'h044);
    cycle();
    mem_rvalid = 1'b1;
    cycle();
    idle(1);

    // Spurious responses in IDLE, and a write-done arriving during a read.
    mem_rvalid = 1'b1;
    mem_wdone  = 1'b1;
    cycle();
    check("spur_wfull0", 32'(wfull_o[0]), 32'h0);
    check("spur_wfull1", 32'(wfull_o[1]), 32'h0);
    rreq[0]  = 1'b1;
    raddr[0] = 13'h055;
    cycle();
    mem_wdone = 1'b1;
    cycle();
    check("spur_still_reading", 32'(mem_rreq), 32'h1);
    mem_rvalid = 1'b1;
    cycle();
    idle(2);

    // Random traffic with random memory latency and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!rreq[n] && $urandom_range(0, 3) == 0) begin
          rreq[n]  = 1'b1;
          raddr[n] = AW'($urandom());
        end
        wreq[n]  = ($urandom_range(0, 5) == 0);
        waddr[n] = AW'($urandom());
        wdata[n] = BW'($urandom());
      end
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_wdone  = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom();
      cycle();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
